// File: rtl/mem_ctrl_burst_if.sv
// mem_ctrl_burst_if
// Bundles the CPU-side request/response handshakes and the byte-wide RAM/IO
// bus of mem_ctrl_burst.
//   slave  : the controller's view (requests and mem_din in; readies,
//            responses and the RAM bus out)
//   master : the CPU core / RAM side (the opposite directions)
// Parameters must match those of the mem_ctrl_burst instance it connects to.
interface mem_ctrl_burst_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 4,
  parameter int TAG_WIDTH  = 4
);
  // RAM / IO bus
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [ADDR_WIDTH-1:0]   mem_aout;
  logic                    mem_rw;

  // Data port
  logic                    d_req_valid;
  logic                    d_req_ready;
  logic                    d_req_we;
  logic [ADDR_WIDTH-1:0]   d_req_addr;
  logic [31:0]             d_req_wdata;
  logic [1:0]              d_req_size;
  logic                    d_req_signed;
  logic [TAG_WIDTH-1:0]    d_req_tag;
  logic                    d_resp_valid;
  logic [31:0]             d_resp_data;
  logic [TAG_WIDTH-1:0]    d_resp_tag;

  // Instruction (line refill) port
  logic                    i_req_valid;
  logic                    i_req_ready;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic                    i_resp_valid;
  logic [8*LINE_BYTES-1:0] i_resp_line;
  logic [ADDR_WIDTH-1:0]   i_resp_addr;

  modport slave (
    input  mem_din,
    output mem_dout, mem_aout, mem_rw,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_size,
           d_req_signed, d_req_tag,
    output d_req_ready, d_resp_valid, d_resp_data, d_resp_tag,
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_line, i_resp_addr
  );

  modport master (
    output mem_din,
    input  mem_dout, mem_aout, mem_rw,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata, d_req_size,
           d_req_signed, d_req_tag,
    input  d_req_ready, d_resp_valid, d_resp_data, d_resp_tag,
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_line, i_resp_addr
  );
endinterface

// File: rtl/mem_ctrl_burst.sv
// mem_ctrl_burst
// Byte-serial memory controller between the CPU core and a single-port 8-bit
// RAM/IO bus. Arbitrates a data port (byte/half/word loads and stores) and an
// instruction port (LINE_BYTES cache-line refills), serialises each request
// into byte beats, and returns extended load data, store acks or whole lines.
// Ports:
//   clk            clock, rising edge
//   rst_in         asynchronous active-high reset
//   rdy_in         global enable; low freezes every register
//   flush          aborts loads/fetches, blocks acceptance in IDLE
//   io_buffer_full stalls store beats that target the IO region
//   bus            mem_ctrl_burst_if.slave: handshakes, responses, RAM bus
// The IO region is addr[17:16] == 2'b11, so ADDR_WIDTH must be at least 18.
module mem_ctrl_burst #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_BYTES   = 4,
  parameter int TAG_WIDTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush,
  input  logic            io_buffer_full,
  mem_ctrl_burst_if.slave bus
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BEAT_W = OFF_W + 1;  // must count up to LINE_BYTES inclusive
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, FETCH} state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [BEAT_W-1:0]       nbeats_q, nbeats_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    signed_q, signed_d;
  logic [TAG_WIDTH-1:0]    tag_q, tag_d;
  logic [8*LINE_BYTES-1:0] line_q, line_d;
  logic [3:0]              starve_q, starve_d;

  logic                    d_resp_valid_q, d_resp_valid_d;
  logic [31:0]             d_resp_data_q, d_resp_data_d;
  logic [TAG_WIDTH-1:0]    d_resp_tag_q, d_resp_tag_d;
  logic                    i_resp_valid_q, i_resp_valid_d;
  logic [8*LINE_BYTES-1:0] i_resp_line_q, i_resp_line_d;
  logic [ADDR_WIDTH-1:0]   i_resp_addr_q, i_resp_addr_d;

  logic                    idle_open;
  logic                    starve_hit;
  logic                    d_fire, i_fire;
  logic [ADDR_WIDTH-1:0]   cur_addr, prev_addr;
  logic                    beat_live;
  logic                    store_stall;
  logic [7:0]              store_byte;

  // Zero/sign extension from the top byte actually fetched.
  function automatic logic [31:0] extend_load(input logic [31:0]       raw,
                                              input logic [BEAT_W-1:0] nbeats,
                                              input logic              sgn);
    logic [31:0] res;
    res = raw;
    if (nbeats == BEAT_W'(1))
      res = {{24{sgn & raw[7]}}, raw[7:0]};
    else if (nbeats == BEAT_W'(2))
      res = {{16{sgn & raw[15]}}, raw[15:0]};
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Handshake / arbitration
  // ---------------------------------------------------------------------
  assign idle_open  = (state_q == IDLE) && rdy_in && !flush && !rst_in;
  assign starve_hit = (starve_q == 4'(STARVE_LIMIT));

  // Data port wins ties unless the instruction port has lost STARVE_LIMIT
  // times in a row; the two readies are mutually exclusive when both valid.
  assign bus.d_req_ready = idle_open && !(bus.i_req_valid && starve_hit);
  assign bus.i_req_ready = idle_open && (starve_hit || !bus.d_req_valid);
  assign d_fire = bus.d_req_valid && bus.d_req_ready;
  assign i_fire = bus.i_req_valid && bus.i_req_ready;

  // ---------------------------------------------------------------------
  // Beat addressing (wraps naturally modulo 2^ADDR_WIDTH)
  // ---------------------------------------------------------------------
  assign cur_addr    = base_q + ADDR_WIDTH'(beat_q);
  assign prev_addr   = cur_addr - ADDR_WIDTH'(1);
  assign beat_live   = (state_q != IDLE) && (beat_q < nbeats_q);
  assign store_stall = (state_q == STORE) && (cur_addr[17:16] == 2'b11) &&
                       io_buffer_full;

  always_comb begin
    store_byte = 8'h00;
    for (int k = 0; k < 4; k++)
      if (beat_q == BEAT_W'(k)) store_byte = wdata_q[8*k +: 8];
  end

  // RAM bus drive
  always_comb begin
    bus.mem_aout = '0;
    bus.mem_dout = 8'h00;
    bus.mem_rw   = 1'b0;
    if (state_q == STORE) begin
      bus.mem_aout = cur_addr;
      bus.mem_dout = store_byte;
      bus.mem_rw   = rdy_in && !store_stall;
    end else if (state_q == LOAD || state_q == FETCH) begin
      if (!rdy_in) begin
        // While frozen, present the address of the byte still owed to the
        // capture register, so mem_din carries it again when rdy_in returns.
        if (beat_q != '0) bus.mem_aout = prev_addr;
      end else if (beat_live) begin
        bus.mem_aout = cur_addr;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    nbeats_d       = nbeats_q;
    base_d         = base_q;
    wdata_d        = wdata_q;
    signed_d       = signed_q;
    tag_d          = tag_q;
    line_d         = line_q;
    starve_d       = starve_q;
    d_resp_valid_d = d_resp_valid_q;
    d_resp_data_d  = d_resp_data_q;
    d_resp_tag_d   = d_resp_tag_q;
    i_resp_valid_d = i_resp_valid_q;
    i_resp_line_d  = i_resp_line_q;
    i_resp_addr_d  = i_resp_addr_q;

    // With rdy_in low everything holds, including a pending response pulse.
    if (rdy_in) begin
      d_resp_valid_d = 1'b0;
      i_resp_valid_d = 1'b0;

      unique case (state_q)
        IDLE: begin
          if (d_fire) begin
            state_d  = bus.d_req_we ? STORE : LOAD;
            base_d   = bus.d_req_addr;
            wdata_d  = bus.d_req_wdata;
            signed_d = bus.d_req_signed;
            tag_d    = bus.d_req_tag;
            beat_d   = '0;
            line_d   = '0;
            unique case (bus.d_req_size)
              2'd0:    nbeats_d = BEAT_W'(1);
              2'd1:    nbeats_d = BEAT_W'(2);
              default: nbeats_d = BEAT_W'(4);
            endcase
            if (bus.i_req_valid) starve_d = starve_q + 4'd1;
          end else if (i_fire) begin
            state_d  = FETCH;
            base_d   = bus.i_req_addr & ~LINE_MASK;
            nbeats_d = BEAT_W'(LINE_BYTES);
            beat_d   = '0;
            line_d   = '0;
            starve_d = 4'd0;
          end
        end

        LOAD, FETCH: begin
          if (flush) begin
            state_d = IDLE;
          end else begin
            // mem_din answers the address driven one cycle earlier, so in
            // the cycle with beat index k it carries byte k-1.
            for (int k = 0; k < LINE_BYTES; k++)
              if (beat_q == BEAT_W'(k + 1)) line_d[8*k +: 8] = bus.mem_din;
            if (beat_q == nbeats_q) begin
              state_d = IDLE;
              if (state_q == LOAD) begin
                d_resp_valid_d = 1'b1;
                d_resp_data_d  = extend_load(line_d[31:0], nbeats_q, signed_q);
                d_resp_tag_d   = tag_q;
              end else begin
                i_resp_valid_d = 1'b1;
                i_resp_line_d  = line_d;
                i_resp_addr_d  = base_q;
              end
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
        end

        STORE: begin
          // Stores ignore flush: a half-written word must not be left behind.
          if (!store_stall) begin
            if (beat_q == nbeats_q - BEAT_W'(1)) begin
              state_d        = IDLE;
              d_resp_valid_d = 1'b1;
              d_resp_data_d  = 32'h0;
              d_resp_tag_d   = tag_q;
            end else begin
              beat_d = beat_q + BEAT_W'(1);
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      nbeats_q       <= '0;
      base_q         <= '0;
      wdata_q        <= '0;
      signed_q       <= 1'b0;
      tag_q          <= '0;
      line_q         <= '0;
      starve_q       <= 4'd0;
      d_resp_valid_q <= 1'b0;
      d_resp_data_q  <= '0;
      d_resp_tag_q   <= '0;
      i_resp_valid_q <= 1'b0;
      i_resp_line_q  <= '0;
      i_resp_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      nbeats_q       <= nbeats_d;
      base_q         <= base_d;
      wdata_q        <= wdata_d;
      signed_q       <= signed_d;
      tag_q          <= tag_d;
      line_q         <= line_d;
      starve_q       <= starve_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_data_q  <= d_resp_data_d;
      d_resp_tag_q   <= d_resp_tag_d;
      i_resp_valid_q <= i_resp_valid_d;
      i_resp_line_q  <= i_resp_line_d;
      i_resp_addr_q  <= i_resp_addr_d;
    end
  end

  // Response pulses are only visible while enabled; a pulse registered just
  // before rdy_in dropped is therefore emitted once rdy_in returns.
  assign bus.d_resp_valid = d_resp_valid_q && rdy_in;
  assign bus.d_resp_data  = d_resp_data_q;
  assign bus.d_resp_tag   = d_resp_tag_q;
  assign bus.i_resp_valid = i_resp_valid_q && rdy_in;
  assign bus.i_resp_line  = i_resp_line_q;
  assign bus.i_resp_addr  = i_resp_addr_q;

endmodule
